timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of PRESET/COUNT (1..32); bits above CNT_W read 0, writes ignored.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: addr  input  2  word offset (bus address bits [3:2]).
REQ-005 SHALL have port: we  input  1  write strobe, qualified by the bridge device hit.
REQ-006 SHALL have port: wd  input  32  write data.
REQ-007 SHALL have port: rd  output  32  read data, combinational from addr and current registers.
REQ-008 SHALL have port: irq  output  1  interrupt request, registered.

Function
REQ-009 SHALL map the registers as follows: offset 0 = CTRL (bit0 EN, bits[2:1] MODE, bit3 IM, rest read 0); offset 1 = PRESET (R/W); offset 2 = COUNT (read-only, writes ignored); offset 3 reads 0 and ignores writes.
REQ-010 SHALL commit register writes at the clk edge where we=1; rd SHALL reflect the new value from the following cycle.
REQ-011 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-012 SHALL, in IDLE, move to LOAD when EN=1 and otherwise stay in IDLE.
REQ-013 SHALL, in LOAD, set COUNT<=PRESET and move to CNT.
REQ-014 SHALL, in CNT: go to IDLE with COUNT held if EN=0; go to INT if COUNT==0; otherwise set COUNT<=COUNT-1.
REQ-015 SHALL, on entering INT, set irq_flag; irq = irq_flag & IM.
REQ-016 SHALL handle MODE 0 (one-shot) in INT: clear EN, go to IDLE, and hold irq_flag until the next CTRL write.
REQ-017 SHALL handle MODE 1 (auto-reload) in INT: keep irq_flag for exactly one cycle, then go to LOAD.
REQ-018 SHALL treat MODE 2/3 as MODE 0.
REQ-019 SHALL, for PRESET=0, pass IDLE->LOAD->CNT->INT with no decrement, so INT is reached 3 cycles after EN is set.
REQ-020 SHALL, for PRESET=N, reach INT N+3 cycles after the edge that wrote EN=1.
REQ-021 SHALL NOT disturb a running COUNT on a PRESET write; the new value applies at the next LOAD.
REQ-022 SHALL, on a CTRL write, clear irq_flag; if the write coincides with entry to INT, irq_flag SHALL be set (the event is not lost).
REQ-023 SHALL, on a CTRL write in the same cycle as the MODE 0 hardware EN clear, give the written EN value priority.
REQ-024 SHALL keep COUNT decrementing as unsigned with no wrap below 0; 0 always diverts to INT.

Reset
REQ-025 SHALL, while reset_n=0 and independent of clk, force CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0, and rd equal to 0 for all offsets.
REQ-026 SHALL abort any count in progress when reset is asserted, and SHALL stay in IDLE after release until EN is written.

Configuration
REQ-027 SHALL, with TIMER_CTRL_AUTO_RELOAD_EN defined, implement MODE 1 per REQ-017.
REQ-028 SHALL, without TIMER_CTRL_AUTO_RELOAD_EN, treat MODE 1 as MODE 0, with the MODE bits still readable as written.

Structure
REQ-029 SHALL place the FSM state enum, register offsets, CTRL bit positions and MODE encodings in the shared package timer_ctrl_pkg.
REQ-030 SHALL be a single flat module with no sub-module; the register file and FSM are too small to split.

Verification
REQ-031 SHALL verify one-shot: PRESET=5, CTRL=0x9 -> irq rises 8 cycles after the CTRL write edge, COUNT=0, EN reads 0, irq stays 1 until a CTRL write of 0x0, then falls the next cycle.
REQ-032 SHALL verify auto-reload: PRESET=3, CTRL=0xB -> a 1-cycle irq pulse every 6 cycles, COUNT reloads to 3 after each pulse.
REQ-033 SHALL verify pause/resume: PRESET=10, enable, write CTRL=0x0 when COUNT=6 -> COUNT holds 6 and state is IDLE; re-enabling reloads COUNT to 10.
REQ-034 SHALL verify boundaries: PRESET=0 with EN=1 -> irq 3 cycles after enable; a write to offset 2 or 3 -> no register change and offset 3 reads 0.
REQ-035 SHALL verify the race: a CTRL write of 0x9 coincident with INT entry -> irq_flag set and EN reads 1.
REQ-036 SHALL verify reset mid-count: reset_n low while COUNT=4 -> all registers 0 and irq=0 immediately, with no counting after release.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared FSM states, register offsets, CTRL bit positions and MODE codes.
package timer_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_e;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
endpackage

// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-mapped down-counter timer with one-shot/auto-reload interrupt.
// Auto-reload (MODE 1) exists only when TIMER_CTRL_AUTO_RELOAD_EN is defined.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);
  state_e state_q, state_d;
  logic en_q, en_d, im_q, im_d, flag_q, flag_d;
  logic [1:0] mode_q, mode_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic ctrl_wr, preset_wr, reload, enter_int;
  logic unused_wd;
  assign unused_wd = &{1'b0, wd};
  assign ctrl_wr   = we && addr == OFF_CTRL;
  assign preset_wr = we && addr == OFF_PRESET;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
  assign reload = mode_q == MODE_RELOAD;
`else
  assign reload = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      flag_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = en_q ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT:  state_d = !en_q ? ST_IDLE : count_q == '0 ? ST_INT : ST_CNT;
      ST_INT:  state_d = reload ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  assign enter_int = state_q == ST_CNT && en_q && count_q == '0;
  always_comb begin
    count_d  = state_q == ST_LOAD ? preset_q
             : (state_q == ST_CNT && en_q && count_q != '0) ? count_q - CNT_W'(1) : count_q;
    preset_d = preset_wr ? wd[CNT_W-1:0] : preset_q;
    // Software EN wins over the one-shot hardware clear; INT entry wins over a CTRL-write clear.
    en_d     = ctrl_wr ? wd[CTRL_EN] : (state_q == ST_INT && !reload) ? 1'b0 : en_q;
    mode_d   = ctrl_wr ? wd[CTRL_MODE_HI:CTRL_MODE_LO] : mode_q;
    im_d     = ctrl_wr ? wd[CTRL_IM] : im_q;
    flag_d   = enter_int || (flag_q && !ctrl_wr && !(state_q == ST_INT && reload));
  end
  always_comb
    rd = addr == OFF_CTRL   ? {28'd0, im_q, mode_q, en_q}
       : addr == OFF_PRESET ? 32'(preset_q)
       : addr == OFF_COUNT  ? 32'(count_q) : 32'd0;
  assign irq = flag_q & im_q;
endmodule
